sobel_window_gen: RTL and testbench

Upstream stage of the Sobel filter. Accepts a raster-order pixel stream (one 8-bit component per pixel) and produces a sliding 3x3 neighbourhood per accepted pixel once two full lines plus two pixels are buffered. Holds the two previous image lines in internal line buffers. Drives the filter's window input through a valid/ready handshake with one output register stage.

---
 rtl/sobel_window_gen.sv | 154 +++++++++++++++
 tb/tb_sobel_window_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_gen.sv
// 3x3 sliding-window generator for the Sobel filter: buffers two previous lines
// and emits one valid-region neighbourhood per accepted pixel through a single output register.
module sobel_window_gen #(
  parameter int PIX_W     = 8,
  parameter int MAX_WIDTH = 640,
  parameter int CNT_W     = $clog2(MAX_WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CNT_W-1:0]   cfg_width,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [PIX_W-1:0]   s_data,
  input  logic               s_sof,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [9*PIX_W-1:0] m_win,
  output logic               m_sof,
  output logic               m_eol
);

  // Handshake: a transfer happens on a rising clk edge where valid & ready are both
  // high; valid never waits for ready, and payload is held while valid & ~ready.

  typedef enum logic [1:0] {
    ROW0 = 2'd0,
    ROW1 = 2'd1,
    ROWN = 2'd2
  } row_state_t;

  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [CNT_W-1:0] MIN_W = CNT_W'(3);
  localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MAX_WIDTH);

  logic [CNT_W-1:0]   width_q;
  logic [CNT_W-1:0]   col_q, col_nxt;
  row_state_t         row_q, row_nxt;
  logic               row2_q, row2_nxt;
  logic [9*PIX_W-1:0] win_q, win_nxt;

  logic [PIX_W-1:0]   lb0 [MAX_WIDTH];
  logic [PIX_W-1:0]   lb1 [MAX_WIDTH];

  logic               accept;
  logic [CNT_W-1:0]   cfg_clamped;
  logic [CNT_W-1:0]   w_eff;
  logic [CNT_W-1:0]   c_eff;
  row_state_t         row_eff;
  logic               row2_eff;
  logic               last_col;
  logic               emit;
  logic [AW-1:0]      lb_addr;
  logic [3*PIX_W-1:0] new_col;

  assign s_ready = ~m_valid | m_ready;
  assign accept  = s_valid & s_ready;

  always_comb begin
    cfg_clamped = cfg_width;
    if (cfg_width < MIN_W)
      cfg_clamped = MIN_W;
    else if (cfg_width > MAX_W)
      cfg_clamped = MAX_W;
  end

  // A start-of-frame pixel is classified as row 0, column 0 regardless of prior state.
  assign w_eff    = s_sof ? cfg_clamped : width_q;
  assign c_eff    = s_sof ? '0 : col_q;
  assign row_eff  = s_sof ? ROW0 : row_q;
  assign row2_eff = s_sof ? 1'b0 : row2_q;
  assign last_col = (c_eff == (w_eff - CNT_W'(1)));
  assign emit     = (row_eff == ROWN) && (c_eff >= CNT_W'(2));
  assign lb_addr  = c_eff[AW-1:0];

  // Column entering the window, row 0 (oldest) in the low bits.
  assign new_col = {s_data, lb0[lb_addr], lb1[lb_addr]};

  always_comb begin
    win_nxt = '0;
    for (int i = 0; i < 3; i++) begin
      win_nxt[PIX_W*(3*i+0) +: PIX_W] = win_q[PIX_W*(3*i+1) +: PIX_W];
      win_nxt[PIX_W*(3*i+1) +: PIX_W] = win_q[PIX_W*(3*i+2) +: PIX_W];
      win_nxt[PIX_W*(3*i+2) +: PIX_W] = new_col[PIX_W*i +: PIX_W];
    end
  end

  // Row/column tracking; row2 marks the first row that is allowed to emit.
  always_comb begin
    row_nxt  = row_q;
    col_nxt  = col_q;
    row2_nxt = row2_q;
    if (accept) begin
      if (last_col) begin
        col_nxt  = '0;
        row2_nxt = (row_eff == ROW1);
        case (row_eff)
          ROW0:    row_nxt = ROW1;
          ROW1:    row_nxt = ROWN;
          default: row_nxt = ROWN;
        endcase
      end else begin
        col_nxt  = c_eff + CNT_W'(1);
        row_nxt  = row_eff;
        row2_nxt = row2_eff;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q   <= ROW0;
      col_q   <= '0;
      row2_q  <= 1'b0;
      width_q <= MAX_W;
      win_q   <= '0;
    end else begin
      row_q  <= row_nxt;
      col_q  <= col_nxt;
      row2_q <= row2_nxt;
      if (accept) begin
        win_q <= win_nxt;
        if (s_sof)
          width_q <= cfg_clamped;
      end
    end
  end

  // Line buffers are never cleared; emission gating keeps stale data out of the output.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[lb_addr] <= lb0[lb_addr];
      lb0[lb_addr] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_win   <= '0;
      m_sof   <= 1'b0;
      m_eol   <= 1'b0;
    end else if (accept) begin
      m_valid <= emit;
      if (emit) begin
        m_win <= win_nxt;
        m_sof <= row2_eff && (c_eff == CNT_W'(2));
        m_eol <= last_col;
      end
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen: raster frames with pixel = 16*row+col,
// captured windows checked against a neighbourhood model and hand constants.
module tb_sobel_window_gen;

  localparam int PIX_W = 8;
  localparam int CNT_W = 10;

  logic               clk;
  logic               rst_n;
  logic [CNT_W-1:0]   cfg_width;
  logic               s_valid;
  logic               s_ready;
  logic [PIX_W-1:0]   s_data;
  logic               s_sof;
  logic               m_valid;
  logic               m_ready;
  logic [9*PIX_W-1:0] m_win;
  logic               m_sof;
  logic               m_eol;

  int vectors = 0;
  int errors  = 0;

  logic [71:0] got_win[$];
  logic        got_sof[$];
  logic        got_eol[$];

  logic        stall_prev = 1'b0;
  logic [71:0] held_win;
  logic        held_sof, held_eol;

  sobel_window_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_width (cfg_width),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_sof     (s_sof),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_win     (m_win),
    .m_sof     (m_sof),
    .m_eol     (m_eol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] observed, input logic [71:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Capture every transfer; while stalled the payload must not move.
  always @(negedge clk) begin
    if (stall_prev && m_valid) begin
      chk("stall_win", m_win, held_win);
      chk("stall_sof", 72'(m_sof), 72'(held_sof));
      chk("stall_eol", 72'(m_eol), 72'(held_eol));
    end
    if (m_valid && m_ready && rst_n) begin
      got_win.push_back(m_win);
      got_sof.push_back(m_sof);
      got_eol.push_back(m_eol);
    end
    stall_prev = m_valid && !m_ready && rst_n;
    held_win   = m_win;
    held_sof   = m_sof;
    held_eol   = m_eol;
  end

  function automatic logic [71:0] exp_win(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[8*(3*i+j) +: 8] = 8'(16 * (r - 2 + i) + (c - 2 + j));
    return w;
  endfunction

  task automatic clear_capture();
    got_win.delete();
    got_sof.delete();
    got_eol.delete();
  endtask

  // mode 0: m_ready=1, mode 1: m_ready pattern 1-0-0-1, mode 2: m_ready=0
  task automatic send_frame(input int w, input int cfg, input int n_pix, input int mode);
    int k;
    int cyc;
    logic acc;
    k = 0;
    cyc = 0;
    cfg_width = CNT_W'(cfg);
    while (k < n_pix && cyc < 4 * n_pix + 20) begin
      s_valid = 1'b1;
      s_data  = 8'(16 * (k / w) + (k % w));
      s_sof   = (k == 0);
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: m_ready = 1'b0;
      endcase
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      if (acc) k++;
      cyc++;
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;
    chk("frame_accept_count", 72'(k), 72'(n_pix));
  endtask

  task automatic drain();
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input int w, input int h);
    int n_exp;
    int n_cmp;
    int r, c;
    n_exp = (w - 2) * (h - 2);
    chk({tag, "_count"}, 72'(got_win.size()), 72'(n_exp));
    n_cmp = (got_win.size() < n_exp) ? got_win.size() : n_exp;
    for (int n = 0; n < n_cmp; n++) begin
      r = 2 + n / (w - 2);
      c = 2 + n % (w - 2);
      chk({tag, "_win"}, got_win[n], exp_win(r, c));
      chk({tag, "_sof"}, 72'(got_sof[n]), 72'(n == 0));
      chk({tag, "_eol"}, 72'(got_eol[n]), 72'(c == w - 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    cfg_width = '0;
    s_valid   = 1'b0;
    s_data    = '0;
    s_sof     = 1'b0;
    m_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", 72'(m_valid), 72'(0));
    chk("rst_s_ready", 72'(s_ready), 72'(1));
    chk("rst_m_win",   m_win,        72'(0));
    chk("rst_m_sof",   72'(m_sof),   72'(0));
    chk("rst_m_eol",   72'(m_eol),   72'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 4x4 frame, always ready
    clear_capture();
    send_frame(4, 4, 16, 0);
    drain();
    if (got_win.size() >= 4) begin
      chk("s1_first_win", got_win[0], 72'h22_21_20_12_11_10_02_01_00);
      chk("s1_first_sof", 72'(got_sof[0]), 72'(1));
      chk("s1_first_eol", 72'(got_eol[0]), 72'(0));
      chk("s1_second_newest", 72'(got_win[1][71:64]), 72'h23);
      chk("s1_second_eol", 72'(got_eol[1]), 72'(1));
      chk("s1_last_newest", 72'(got_win[3][71:64]), 72'h33);
    end
    check_frame("s1", 4, 4);

    // Same frame with downstream back-pressure
    clear_capture();
    send_frame(4, 4, 16, 1);
    drain();
    check_frame("s2", 4, 4);

    // Undersized cfg_width clamps to 3
    clear_capture();
    send_frame(3, 1, 9, 0);
    drain();
    chk("s3_count", 72'(got_win.size()), 72'(1));
    if (got_win.size() >= 1) begin
      chk("s3_win", got_win[0], 72'h22_21_20_12_11_10_02_01_00);
      chk("s3_newest", 72'(got_win[0][71:64]), 72'h22);
      chk("s3_sof", 72'(got_sof[0]), 72'(1));
      chk("s3_eol", 72'(got_eol[0]), 72'(1));
    end

    // Aborted frame followed by a complete one
    clear_capture();
    send_frame(4, 4, 6, 0);
    send_frame(4, 4, 16, 0);
    drain();
    check_frame("s4", 4, 4);

    // Asynchronous reset while a window is stalled
    clear_capture();
    send_frame(4, 4, 11, 2);
    chk("s5_pending_valid", 72'(m_valid), 72'(1));
    chk("s5_pending_ready", 72'(s_ready), 72'(0));
    chk("s5_pending_win", m_win, 72'h22_21_20_12_11_10_02_01_00);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s5_rst_valid", 72'(m_valid), 72'(0));
    chk("s5_rst_ready", 72'(s_ready), 72'(1));
    chk("s5_rst_win", m_win, 72'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_capture();
    send_frame(4, 4, 16, 0);
    drain();
    check_frame("s5", 4, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
